// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed scan driver for common-anode 7-segment digits
//
// Purpose:
//   Walks through NUM_DIG digit slots of CLK_DIV cycles each. Every slot opens
//   with BLANK_CYC cycles where all selects are off, which prevents ghosting.
//   The rest of the slot drives the select for the current digit. The nibble and
//   decimal point for the slot are presented for the whole slot, so the
//   downstream segment lookup has settled before the select turns on. New
//   display words are taken into a shadow register and moved to the display
//   register only at a frame start, so a frame never mixes two words.
//
// Ports:
//   iCLK    in   1          system clock
//   iRST    in   1          synchronous active-high reset
//   iDATA   in   4*NUM_DIG  nibble k = digit k, digit 0 rightmost
//   iDP     in   NUM_DIG    decimal-point request per digit, active-high
//   iLOAD   in   1          strobe: capture iDATA/iDP into shadow
//   iLZ_EN  in   1          leading-zero suppression enable
//   oDIG    out  4          nibble to segment lookup
//   oDP     out  1          decimal point, active-low
//   oSEL    out  NUM_DIG    digit selects, active-low, one-cold or all ones
//   oFRAME  out  1          pulse on first cycle of digit 0's slot

module seg7_scan_mux #(
  parameter int NUM_DIG   = 8,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [4*NUM_DIG-1:0]   iDATA,
  input  logic [NUM_DIG-1:0]     iDP,
  input  logic                   iLOAD,
  input  logic                   iLZ_EN,
  output logic [3:0]             oDIG,
  output logic                   oDP,
  output logic [NUM_DIG-1:0]     oSEL,
  output logic                   oFRAME
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIG);

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } phase_t;

  phase_t                 r_phase;
  phase_t                 w_phase_nxt;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [4*NUM_DIG-1:0]   r_shadow;
  logic [NUM_DIG-1:0]     r_shadow_dp;
  logic [4*NUM_DIG-1:0]   r_disp;
  logic [NUM_DIG-1:0]     r_disp_dp;
  logic                   r_pending;

  logic                   w_slot_end;
  logic                   w_blank_end;
  logic                   w_last_dig;
  logic                   w_frame_wrap;
  logic [NUM_DIG-1:0]     w_sup;
  logic                   w_zero_run;
  logic [3:0]             w_dig;
  logic                   w_dp;
  logic                   w_sup_cur;
  logic [NUM_DIG-1:0]     w_sel_on;
  logic [NUM_DIG-1:0]     w_sel_nxt;
  logic                   w_frame_nxt;

  assign w_slot_end   = (r_cnt == CW'(CLK_DIV - 1));
  assign w_blank_end  = (r_cnt == CW'(BLANK_CYC - 1));
  assign w_last_dig   = (r_idx == IW'(NUM_DIG - 1));
  assign w_frame_wrap = w_slot_end && w_last_dig;
  assign w_frame_nxt  = (r_cnt == '0) && (r_idx == '0);

  // Phase FSM: BLANK covers cnt 0..BLANK_CYC-1, ON covers the rest of the slot.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_phase <= BLANK;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      BLANK:   if (w_blank_end) w_phase_nxt = ON;
      ON:      if (w_slot_end)  w_phase_nxt = BLANK;
      default: w_phase_nxt = BLANK;
    endcase
  end

  // Slot counter and digit index.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CW'(1);
      if (w_slot_end) begin
        r_idx <= w_last_dig ? '0 : r_idx + IW'(1);
      end
    end
  end

  // Shadow/display double buffer. The load check comes after the frame
  // transfer, so a load on the frame-start edge lands in shadow and stays
  // pending for the following frame while disp takes the older shadow.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_frame_wrap && r_pending) begin
        r_disp    <= r_shadow;
        r_disp_dp <= r_shadow_dp;
        r_pending <= 1'b0;
      end
      if (iLOAD) begin
        r_shadow    <= iDATA;
        r_shadow_dp <= iDP;
        r_pending   <= 1'b1;
      end
    end
  end

  // Leading-zero map: walk down from the top digit while nibbles and points
  // are all zero. Digit 0 is left out so it always lights.
  always_comb begin
    w_sup      = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run && (r_disp[4*k +: 4] == 4'd0) && !r_disp_dp[k];
      w_sup[k]   = w_zero_run;
    end
  end

  // Per-slot data select.
  always_comb begin
    w_dig     = 4'd0;
    w_dp      = 1'b0;
    w_sup_cur = 1'b0;
    w_sel_on  = '1;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (r_idx == IW'(k)) begin
        w_dig       = r_disp[4*k +: 4];
        w_dp        = r_disp_dp[k];
        w_sup_cur   = w_sup[k];
        w_sel_on[k] = 1'b0;
      end
    end
  end

  always_comb begin
    w_sel_nxt = '1;
    if ((r_phase == ON) && !(iLZ_EN && w_sup_cur)) begin
      w_sel_nxt = w_sel_on;
    end
  end

  // Registered outputs, one cycle behind the slot state.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oDIG   <= 4'd0;
      oDP    <= 1'b1;
      oSEL   <= '1;
      oFRAME <= 1'b0;
    end else begin
      oDIG   <= w_dig;
      oDP    <= ~w_dp;
      oSEL   <= w_sel_nxt;
      oFRAME <= w_frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux

module tb_seg7_scan_mux;

  localparam int ND = 4;
  localparam int CD = 8;
  localparam int BC = 2;
  localparam int FRAME_CYC = ND * CD;
  // Output sample after which the DUT's frame-start (idx wrap) edge occurs;
  // outputs trail the slot state by one cycle.
  localparam int WRAP_SAMPLE = FRAME_CYC - 2;

  logic            iCLK = 1'b0;
  logic            iRST;
  logic [4*ND-1:0] iDATA;
  logic [ND-1:0]   iDP;
  logic            iLOAD;
  logic            iLZ_EN;
  logic [3:0]      oDIG;
  logic            oDP;
  logic [ND-1:0]   oSEL;
  logic            oFRAME;

  int tests  = 0;
  int failed = 0;
  int frame_no = 0;

  typedef struct {
    logic [3:0] dig;
    logic       dp_n;
    logic [3:0] sel_on;
  } slot_t;

  slot_t sb[$];

  seg7_scan_mux #(.NUM_DIG(ND), .CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iDATA  (iDATA),
    .iDP    (iDP),
    .iLOAD  (iLOAD),
    .iLZ_EN (iLZ_EN),
    .oDIG   (oDIG),
    .oDP    (oDP),
    .oSEL   (oSEL),
    .oFRAME (oFRAME)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_frame(input logic [15:0] d, input logic [3:0] p, input logic lz);
    slot_t rec;
    logic  sup;
    for (int k = 0; k < ND; k++) begin
      rec.dig  = d[4*k +: 4];
      rec.dp_n = ~p[k];
      sup = lz && (k > 0) && ((d >> (4*k)) == 16'd0) && ((p >> k) == 4'd0);
      rec.sel_on = sup ? 4'hF : ~(4'b0001 << k);
      sb.push_back(rec);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    while (oFRAME !== 1'b1 && n < 3 * FRAME_CYC) begin
      @(negedge iCLK);
      n++;
    end
    if (oFRAME !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL wait_frame: oFRAME got %b want 1 within %0d cycles", oFRAME, 3 * FRAME_CYC);
    end
  endtask

  // Checks one full frame against the scoreboard; optionally pulses iLOAD
  // after the output samples numbered la and lb.
  task automatic check_frame(input int la, input logic [15:0] da, input logic [3:0] pa,
                             input int lb, input logic [15:0] db, input logic [3:0] pb);
    slot_t       rec;
    logic [31:0] sel_o, sel_e, dig_o, dig_e;
    logic [7:0]  dp_o, dp_e, fr_o, fr_e;
    int          n;
    wait_frame();
    for (int s = 0; s < ND; s++) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL scoreboard_empty: frame %0d slot %0d got 0 entries want >0", frame_no, s);
        iLOAD = 1'b0;
        return;
      end
      rec = sb.pop_front();
      for (int c = 0; c < CD; c++) begin
        n = s * CD + c;
        if (n > 0) @(negedge iCLK);
        sel_o[c*4 +: 4] = oSEL;
        sel_e[c*4 +: 4] = (c < BC) ? 4'hF : rec.sel_on;
        dig_o[c*4 +: 4] = oDIG;
        dig_e[c*4 +: 4] = rec.dig;
        dp_o[c] = oDP;
        dp_e[c] = rec.dp_n;
        fr_o[c] = oFRAME;
        fr_e[c] = (s == 0) && (c == 0);
        iLOAD = 1'b0;
        if (n == la) begin
          iLOAD = 1'b1; iDATA = da; iDP = pa;
        end
        if (n == lb) begin
          iLOAD = 1'b1; iDATA = db; iDP = pb;
        end
      end
      tests++;
      if (sel_o !== sel_e) begin
        failed++;
        $display("FAIL frame%0d slot%0d oSEL seq: got %h want %h", frame_no, s, sel_o, sel_e);
      end
      tests++;
      if (dig_o !== dig_e) begin
        failed++;
        $display("FAIL frame%0d slot%0d oDIG seq: got %h want %h", frame_no, s, dig_o, dig_e);
      end
      tests++;
      if (dp_o !== dp_e) begin
        failed++;
        $display("FAIL frame%0d slot%0d oDP seq: got %b want %b", frame_no, s, dp_o, dp_e);
      end
      tests++;
      if (fr_o !== fr_e) begin
        failed++;
        $display("FAIL frame%0d slot%0d oFRAME seq: got %b want %b", frame_no, s, fr_o, fr_e);
      end
    end
    iLOAD = 1'b0;
    frame_no++;
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    tests++;
    if (oSEL !== 4'hF || oDIG !== 4'h0 || oDP !== 1'b1 || oFRAME !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: got sel=%b dig=%h dp=%b frame=%b want sel=1111 dig=0 dp=1 frame=0",
               oSEL, oDIG, oDP, oFRAME);
    end
    iRST = 1'b0;
    @(negedge iCLK);
    tests++;
    if (oFRAME !== 1'b1) begin
      failed++;
      $display("FAIL reset_first_frame: oFRAME got %b want 1", oFRAME);
    end
    push_frame(16'h0000, 4'b0000, 1'b0);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    @(negedge iCLK);
    tests++;
    if (oFRAME !== 1'b1) begin
      failed++;
      $display("FAIL frame_period: oFRAME at cycle %0d got %b want 1", FRAME_CYC, oFRAME);
    end
  endtask

  task automatic test_load_midframe();
    push_frame(16'h0000, 4'b0000, 1'b0);
    check_frame(10, 16'h1234, 4'b0100, -1, 16'h0, 4'h0);
    push_frame(16'h1234, 4'b0100, 1'b0);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_lz();
    iLZ_EN = 1'b1;
    push_frame(16'h1234, 4'b0100, 1'b1);
    check_frame(10, 16'h0050, 4'b0000, -1, 16'h0, 4'h0);
    push_frame(16'h0050, 4'b0000, 1'b1);
    check_frame(10, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
    push_frame(16'h0000, 4'b0000, 1'b1);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    iLZ_EN = 1'b0;
  endtask

  task automatic test_frame_edge_load();
    push_frame(16'h0000, 4'b0000, 1'b0);
    check_frame(10, 16'h1111, 4'b0000, WRAP_SAMPLE, 16'hABCD, 4'b0000);
    push_frame(16'h1111, 4'b0000, 1'b0);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    push_frame(16'hABCD, 4'b0000, 1'b0);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_back_to_back();
    push_frame(16'hABCD, 4'b0000, 1'b0);
    check_frame(5, 16'h1111, 4'b0001, 20, 16'h2222, 4'b0000);
    push_frame(16'h2222, 4'b0000, 1'b0);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  task automatic test_reset_mid();
    wait_frame();
    for (int n = 0; n <= 2 * CD + 4; n++) begin
      if (n > 0) @(negedge iCLK);
      iLOAD = 1'b0;
      if (n == 3) begin
        iLOAD = 1'b1; iDATA = 16'h5555; iDP = 4'b1111;
      end
    end
    tests++;
    if (oSEL !== 4'b1011) begin
      failed++;
      $display("FAIL mid_slot2_on: oSEL got %b want 1011", oSEL);
    end
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    tests++;
    if (oSEL !== 4'hF || oDIG !== 4'h0 || oDP !== 1'b1) begin
      failed++;
      $display("FAIL mid_reset_outputs: got sel=%b dig=%h dp=%b want sel=1111 dig=0 dp=1",
               oSEL, oDIG, oDP);
    end
    @(negedge iCLK);
    tests++;
    if (oFRAME !== 1'b1) begin
      failed++;
      $display("FAIL mid_reset_restart: oFRAME got %b want 1", oFRAME);
    end
    push_frame(16'h0000, 4'b0000, 1'b0);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    push_frame(16'h0000, 4'b0000, 1'b0);
    check_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
  endtask

  initial begin
    iRST   = 1'b1;
    iDATA  = '0;
    iDP    = '0;
    iLOAD  = 1'b0;
    iLZ_EN = 1'b0;
    test_reset();
    test_load_midframe();
    test_lz();
    test_frame_edge_load();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed scan driver for a bank of common-anode 7-segment digits.
- Sits directly upstream of the BCD/hex-to-7-segment lookup.
- Each digit slot: selects one nibble of a frame-latched display word and drives it on oDIG to the lookup. Asserts the active-low digit select and the active-low decimal point for that slot.
- Inserts an anti-ghosting blank interval before each digit.
- Supports optional leading-zero suppression and tear-free frame updates.

Parameters:
- NUM_DIG, 8, number of digits scanned; legal range 2..8.
- CLK_DIV, 50000, clock cycles per digit slot; must be at least 4.
- BLANK_CYC, 500, cycles at the start of each slot with all selects off; must be at least 1 and less than CLK_DIV.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  reset.
- iDATA  in  4*NUM_DIG  nibble k = digit k; digit 0 is the least significant and rightmost.
- iDP  in  NUM_DIG  decimal-point request per digit, active-high.
- iLOAD  in  1  one-cycle strobe; captures iDATA/iDP into the shadow register.
- iLZ_EN  in  1  leading-zero suppression enable.
- oDIG  out  4  nibble to the segment lookup.
- oDP  out  1  decimal-point segment, active-low (0 = lit).
- oSEL  out  NUM_DIG  digit selects, active-low, one-cold or all-ones.
- oFRAME  out  1  one-cycle pulse at the first cycle of digit 0's slot.

Behaviour:
- Interface: one clock (iCLK); reset iRST is synchronous and active-high.
- Reset values:
  - idx=0, cnt=0, phase=BLANK.
  - shadow=0, disp=0, pending=0.
  - oSEL all ones, oDIG=0, oDP=1, oFRAME=0.
- Counters:
  - cnt is $clog2(CLK_DIV) bits wide and counts 0..CLK_DIV-1 within a slot.
  - At cnt=CLK_DIV-1: cnt wraps to 0 and idx advances.
  - idx wraps from NUM_DIG-1 to 0; no other wrap point.
- FSM (per slot):
  - BLANK: cnt 0..BLANK_CYC-1; oSEL all ones.
  - ON: cnt BLANK_CYC..CLK_DIV-1; oSEL[idx]=0, all other bits 1, unless the digit is suppressed.
  - BLANK->ON when cnt==BLANK_CYC-1.
  - ON->BLANK when cnt==CLK_DIV-1.
- Output timing:
  - All outputs are registers.
  - oDIG=disp nibble[idx] and oDP=~disp_dp[idx] for the whole slot, BLANK included, so the lookup settles before select.
- Frame update:
  - iLOAD=1 writes shadow and sets pending.
  - At the edge where idx wraps to 0 (frame start) with pending=1: disp<=shadow and pending<=0.
  - iLOAD coinciding with that edge: disp takes the old shadow; the new value goes to shadow and pending stays 1, so it is applied at the next frame.
  - Multiple loads within a frame: the last one wins.
- oFRAME is 1 in the first cycle of slot 0 (cnt=0, idx=0), including the first cycle after reset release.
- Leading-zero suppression (iLZ_EN=1):
  - Digit k is suppressed if disp nibbles k..NUM_DIG-1 are all 0 and disp_dp for k..NUM_DIG-1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps oSEL all ones through ON.
  - Suppression is computed from disp only, so it is stable within a frame.
  - iLZ_EN is sampled each cycle.
- Reset mid-operation: iRST=1 in any cycle restores all reset values at that edge, discarding shadow and pending. Scanning restarts at digit 0 BLANK after release.
- oSEL is never more than one-cold in any cycle.

Test Plan (NUM_DIG=4, CLK_DIV=8, BLANK_CYC=2):
- Reset release, iDATA=0 with no load:
  - oFRAME=1 at cycle 0.
  - oSEL=1111 on cycles 0-1, 1110 on cycles 2-7, 1111 on 8-9, 1101 on 10-15.
  - Period is 32 cycles; oDIG=0 throughout.
- iLOAD with iDATA=16'h1234, iDP=4'b0100, mid-frame:
  - Display is unchanged until the next oFRAME.
  - Then oDIG=4, 3, 2, 1 on slots 0-3.
  - oDP=0 only in slot 2.
- iLZ_EN=1, load 16'h0050, iDP=0:
  - Slots 3 and 2 are fully dark (oSEL=1111).
  - Slot 1 shows 5; slot 0 shows 0 with oSEL=1110 during ON.
  - Load 16'h0000: only digit 0 is lit.
- iLOAD asserted exactly on a frame-start edge with 16'hABCD, after a prior pending 16'h1111:
  - This frame shows 1111.
  - The next frame shows ABCD.
- Two loads, 16'h1111 then 16'h2222, in one frame: the next frame shows 2222; 1111 is never displayed.
- iRST pulsed during slot 2 ON with pending data:
  - Next cycle: oSEL=1111, oDIG=0, oDP=1.
  - Scanning resumes at digit 0.
  - Pending data is lost; display stays 0.
